// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// icache_if : core-fetch and instruction-memory signals of icache_ctrl
// Rev 1.0
// ============================================================================
interface icache_if #(
  parameter int WORD_SIZE        = 32,
  parameter int ICACHE_LINE_SIZE = 128
);
  logic [WORD_SIZE-1:0]        PC;
  logic                        Fetch;
  logic                        Invalidate;
  logic [WORD_SIZE-1:0]        Instr;
  logic                        Stall;
  logic                        MemRead;
  logic [WORD_SIZE-1:0]        MemPC;
  logic                        MemReady;
  logic [ICACHE_LINE_SIZE-1:0] MemLine;
  logic [15:0]                 MissCount;

  modport slave (
    input  PC, Fetch, Invalidate, MemReady, MemLine,
    output Instr, Stall, MemRead, MemPC, MissCount
  );

  modport master (
    output PC, Fetch, Invalidate, MemReady, MemLine,
    input  Instr, Stall, MemRead, MemPC, MissCount
  );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// icache_ctrl : direct-mapped instruction cache, zero-cycle hit, line refill
// Rev 1.0
// ============================================================================
module icache_ctrl #(
  parameter int WORD_SIZE        = 32,
  parameter int ICACHE_LINE_SIZE = 128,
  parameter int NUM_LINES        = 4
) (
  input wire logic  clk,
  input wire logic  rst,
  icache_if.slave   bus
);
  localparam int WORDS   = ICACHE_LINE_SIZE / WORD_SIZE;
  localparam int BYTE_W  = $clog2(WORD_SIZE / 8);
  localparam int WSEL_W  = $clog2(WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int IDX_LSB = BYTE_W + WSEL_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = WORD_SIZE - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                      state_q;
  logic                        memread_q;
  logic [WORD_SIZE-1:0]        mempc_q;
  logic [15:0]                 misscount_q;
  logic [NUM_LINES-1:0]        valid_q;
  logic [TAG_W-1:0]            tag_q  [NUM_LINES];
  logic [ICACHE_LINE_SIZE-1:0] data_q [NUM_LINES];

  logic [IDX_W-1:0]            w_idx;
  logic [TAG_W-1:0]            w_tag;
  logic [WSEL_W-1:0]           w_wsel;
  logic [IDX_W-1:0]            w_fill_idx;
  logic [TAG_W-1:0]            w_fill_tag;
  logic [ICACHE_LINE_SIZE-1:0] w_line;
  logic                        w_hit;

  assign w_idx      = bus.PC[TAG_LSB-1:IDX_LSB];
  assign w_tag      = bus.PC[WORD_SIZE-1:TAG_LSB];
  assign w_wsel     = bus.PC[IDX_LSB-1:BYTE_W];
  assign w_fill_idx = mempc_q[TAG_LSB-1:IDX_LSB];
  assign w_fill_tag = mempc_q[WORD_SIZE-1:TAG_LSB];

  // Lookup always sees the valid bits as they stood before this edge.
  assign w_line = data_q[w_idx];
  assign w_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

  assign bus.Instr     = w_line[int'(w_wsel)*WORD_SIZE +: WORD_SIZE];
  assign bus.Stall     = (state_q != S_IDLE) || (bus.Fetch && !w_hit);
  assign bus.MemRead   = memread_q;
  assign bus.MemPC     = mempc_q;
  assign bus.MissCount = misscount_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      memread_q   <= 1'b0;
      mempc_q     <= '0;
      misscount_q <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Fetch && !w_hit) begin
            state_q   <= S_REQ;
            memread_q <= 1'b1;
            mempc_q   <= {bus.PC[WORD_SIZE-1:IDX_LSB], {IDX_LSB{1'b0}}};
            if (misscount_q != 16'hFFFF) begin
              misscount_q <= misscount_q + 16'd1;
            end
          end
        end
        // A Ready still high from the previous transfer is not a completion.
        S_REQ: begin
          if (!bus.MemReady) begin
            state_q   <= S_WAIT;
            memread_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.MemReady) begin
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          state_q             <= S_IDLE;
          valid_q[w_fill_idx] <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (bus.Invalidate) begin
        valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FILL) begin
      tag_q[w_fill_idx]  <= w_fill_tag;
      data_q[w_fill_idx] <= bus.MemLine;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_ctrl : randomized scoreboard bench for icache_ctrl
// Rev 1.0
// ============================================================================
module tb_icache_ctrl;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stalled;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inv_stim = 1'b0;
  logic inv_resp = 1'b0;

  always #5 clk = ~clk;

  icache_if bus ();
  assign bus.Invalidate = inv_stim | inv_resp;

  icache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0;
  int   exp_miss = 0;
  bit   mon_en = 1'b0;
  bit   delivered = 1'b0;
  bit   inv_on_fill = 1'b0;
  exp_t sb [$];
  exp_t mon_e;
  logic [31:0] mempc_q [$];
  bit          mv [4];
  bit   [25:0] mt [4];
  logic [25:0] tags [4] = '{26'd0, 26'd1, 26'd2, 26'h3FF_FFFF};

  // Instruction memory contents are a fixed function of the word address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ((w ^ 32'hA5A5_1234) * 32'h9E37_79B1) + 32'h0BAD_F00D;
  endfunction

  function automatic logic [127:0] mkline(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = memword({a[31:4], 4'h0} + 32'(4*k));
    return l;
  endfunction

  function automatic bit lookup(input logic [31:0] pc);
    return mv[pc[5:4]] && (mt[pc[5:4]] == pc[31:6]);
  endfunction

  function automatic void clear_all();
    for (int k = 0; k < 4; k++) mv[k] = 1'b0;
  endfunction

  function automatic void add_miss(input logic [31:0] pc);
    if (exp_miss < 65535) exp_miss++;
    mempc_q.push_back({pc[31:4], 4'h0});
    mv[pc[5:4]] = 1'b1;
    mt[pc[5:4]] = pc[31:6];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input bit inv, input bit want_chg,
                          input logic [31:0] pc2, input bit invfill);
    bit          hit;
    bit          chg;
    logic [31:0] dpc;
    exp_t        e;
    hit = lookup(pc);
    chg = 1'b0;
    dpc = pc;
    if (inv) clear_all();
    if (!hit) begin
      add_miss(pc);
      if (invfill) begin
        clear_all();
        add_miss(pc);
      end else if (want_chg) begin
        chg = 1'b1;
        dpc = pc2;
        if (!lookup(pc2)) add_miss(pc2);
      end
    end
    e.pc      = dpc;
    e.instr   = memword(dpc);
    e.stalled = !hit;
    e.cnt     = 32'(exp_miss);
    sb.push_back(e);
    inv_on_fill = invfill && !hit;
    delivered   = 1'b0;
    bus.PC      = pc;
    bus.Fetch   = 1'b1;
    inv_stim    = inv;
    @(posedge clk);
    #1;
    inv_stim = 1'b0;
    if (chg) bus.PC = pc2;
    for (int i = 0; i < 200; i++) begin
      if (delivered) break;
      @(posedge clk);
      #1;
    end
    if (!delivered) begin
      failures++;
      $display("FAIL fetch_timeout pc=%h delivered=0 expected=1", pc);
      finish_run();
    end
  endtask

  task automatic idle(input int n);
    bus.Fetch = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every delivered instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (!mon_en) begin
      stall_cnt = 0;
    end else if (bus.Fetch) begin
      if (bus.Stall) begin
        stall_cnt++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery pc=%h instr=%h expected=none", bus.PC, bus.Instr);
        end else begin
          mon_e = sb.pop_front();
          chk("instr", bus.Instr, mon_e.instr);
          chk("pc_at_delivery", bus.PC, mon_e.pc);
          chk("stalled", 32'(stall_cnt > 0), 32'(mon_e.stalled));
          chk("misscount", 32'(bus.MissCount), mon_e.cnt);
          chk("memread_at_delivery", 32'(bus.MemRead), 32'd0);
        end
        stall_cnt = 0;
        delivered = 1'b1;
      end
    end else begin
      chk("idle_stall", 32'(bus.Stall), 32'd0);
    end
  end

  // Memory responder: Ready stays high from the last transfer until it
  // chooses to accept a new request; data is garbage while Ready is low.
  initial begin
    logic [31:0] req_pc;
    logic [31:0] a;
    bit          ab;
    int          n;
    bus.MemReady = 1'b1;
    bus.MemLine  = {4{32'hDEAD_BEEF}};
    forever begin
      @(negedge clk);
      if (rst && bus.MemRead) begin
        ab     = 1'b0;
        req_pc = bus.MemPC;
        if (mempc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_request mempc=%h expected=none", req_pc);
        end else begin
          a = mempc_q.pop_front();
          chk("mempc", req_pc, a);
        end
        if (bus.MemReady) begin
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst) begin ab = 1'b1; break; end
            chk("memread_hold", 32'(bus.MemRead), 32'd1);
            chk("mempc_hold", bus.MemPC, req_pc);
          end
        end
        if (!ab) begin
          bus.MemReady = 1'b0;
          bus.MemLine  = {$urandom, $urandom, $urandom, $urandom};
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst) begin ab = 1'b1; break; end
            chk("mempc_wait", bus.MemPC, req_pc);
          end
        end
        if (!ab) begin
          bus.MemLine  = mkline(req_pc);
          bus.MemReady = 1'b1;
          if (inv_on_fill) begin
            @(negedge clk);
            inv_resp = 1'b1;
            @(negedge clk);
            inv_resp    = 1'b0;
            inv_on_fill = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] p;
    logic [31:0] p2;
    bus.PC    = 32'h0;
    bus.Fetch = 1'b0;
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memread", 32'(bus.MemRead), 32'd0);
    chk("rst_mempc", bus.MemPC, 32'd0);
    chk("rst_misscount", 32'(bus.MissCount), 32'd0);
    chk("rst_stall_nofetch", 32'(bus.Stall), 32'd0);
    bus.Fetch = 1'b1;
    #1;
    chk("rst_stall_fetch", 32'(bus.Stall), 32'd1);

    // Reset while the first transfer is waiting on memory.
    bus.PC = 32'h40;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mempc_q.push_back(32'h40);
    for (int i = 0; i < 100; i++) begin
      if (bus.MemRead === 1'b1) break;
      @(posedge clk);
      #1;
    end
    chk("cold_memread", 32'(bus.MemRead), 32'd1);
    chk("cold_mempc", bus.MemPC, 32'h40);
    chk("cold_misscount", 32'(bus.MissCount), 32'd1);
    chk("cold_stall", 32'(bus.Stall), 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (bus.MemRead === 1'b0) break;
      @(posedge clk);
      #1;
    end
    chk("wait_memread", 32'(bus.MemRead), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_memread", 32'(bus.MemRead), 32'd0);
    chk("midrst_misscount", 32'(bus.MissCount), 32'd0);
    chk("midrst_stall", 32'(bus.Stall), 32'd1);
    bus.Fetch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_all();
    exp_miss = 0;
    mempc_q.delete();
    mon_en = 1'b1;

    // Cold miss, hits on the same line, conflict, invalidate during fill.
    do_fetch(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h48, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h4C, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'hC0, 1'b0, 1'b0, 32'h0, 1'b1);
    do_fetch(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h44, 1'b1, 1'b0, 32'h0, 1'b0);
    do_fetch(32'h48, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      p  = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
      p2 = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
      do_fetch(p, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), p2,
               ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("mempc_q_empty", 32'(mempc_q.size()), 32'd0);
    finish_run();
  end
endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction/address width in bits.
REQ-002 Parameter ICACHE_LINE_SIZE, default 128, line width: 4 words.
REQ-003 Parameter NUM_LINES, default 4, direct-mapped entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 PC  input  WORD_SIZE  fetch byte address from core.
REQ-007 Fetch  input  1  core requests an instruction at PC this cycle.
REQ-008 Invalidate  input  1  clear all valid bits.
REQ-009 Instr  output  WORD_SIZE  instruction word for PC; meaningful when Fetch=1 and Stall=0.
REQ-010 Stall  output  1  core holds PC; no instruction delivered.
REQ-011 MemRead  output  1  line request to instruction memory.
REQ-012 MemPC  output  WORD_SIZE  line-aligned miss address, PC with bits [3:0] zero.
REQ-013 MemReady  input  1  memory completion flag; stays high after completion until a new request is accepted.
REQ-014 MemLine  input  ICACHE_LINE_SIZE  returned line, word 0 in bits [31:0]; stable while MemReady=1.
REQ-015 MissCount  output  16  saturating count of misses since reset.

Function
REQ-016 Address split: word select PC[3:2], index PC[5:4], tag PC[31:6]; PC[1:0] ignored.
REQ-017 Storage per entry: valid bit, 26-bit tag, 128-bit data.
REQ-018 States: IDLE, REQ, WAIT, FILL.
REQ-019 IDLE hit (Fetch=1, valid[index], tag match): Stall=0, Instr = word PC[3:2] of the entry, combinationally in the same cycle (zero-cycle hit latency).
REQ-020 IDLE miss (Fetch=1, no hit): Stall=1, latch MemPC, MissCount increments (saturates at 16'hFFFF), next state REQ.
REQ-021 Fetch=0 in IDLE: Stall=0, no state change.
REQ-022 REQ: MemRead=1 for at least one full cycle; leave to WAIT on the first rising edge after entry at which MemReady=0 (stale high Ready from the prior transfer is ignored).
REQ-023 WAIT: MemRead=0; remain until MemReady=1, then go to FILL.
REQ-024 FILL: write MemLine into the entry indexed by MemPC[5:4], set tag = MemPC[31:6], valid=1; next state IDLE.
REQ-025 Stall=1 in REQ, WAIT, FILL regardless of Fetch.
REQ-026 Miss-to-hit latency: the lookup after FILL re-evaluates the current PC; PC changed during the miss produces a fresh lookup, not the filled word.
REQ-027 MemPC is held constant from IDLE-miss until FILL completes.
REQ-028 Invalidate clears all valid bits at the next rising edge in any state; if simultaneous with FILL, Invalidate wins (the entry ends invalid, state still returns to IDLE).
REQ-029 An IDLE lookup in the same cycle as Invalidate uses the pre-clear valid bits.
REQ-030 Fill overwrites any valid entry at the same index (no replacement choice).

Reset
REQ-031 On rst low, immediately: state IDLE, MemRead=0, MemPC=0, all valid bits 0, MissCount=0; Stall follows IDLE rules (Fetch=1 -> miss).
REQ-032 Reset mid-transfer (REQ/WAIT) abandons the transfer; no fill occurs; the first post-reset Fetch issues a new request.
REQ-033 Tag and data arrays need no reset values.

Verification
REQ-034 Cold miss: reset, Fetch=1, PC=0x40 -> Stall=1, MemRead=1, MemPC=0x40, MissCount=1; memory returns line {D,C,B,A} -> entry 0 valid, then Stall=0, Instr=A.
REQ-035 Hits: after REQ-034, PC=0x44/0x48/0x4C -> Instr=B/C/D, Stall=0 each cycle, MemRead stays 0, MissCount=1.
REQ-036 Conflict: PC=0x80 (index 0, new tag) -> miss, refill, MissCount=2; then PC=0x40 -> miss again, MissCount=3.
REQ-037 Stale Ready: MemReady held 1 from prior transfer, new miss -> MemRead held until MemReady seen 0, no capture of stale MemLine.
REQ-038 Invalidate asserted in FILL cycle -> entry invalid, next PC=0x40 lookup misses.
REQ-039 rst low during WAIT -> MemRead=0, MissCount=0, state IDLE; subsequent Fetch at 0x40 misses and completes normally.
